dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//  Multi-cycle data-memory responder: the memory side of the processor data port.
//  Accepts one load/store request at a time over a valid/ready handshake.
//  Inserts WAIT_CYCLES of access latency and returns read data plus an error flag
//  over a second valid/ready handshake.
//  Sits between the core's load/store path and the word-organised data RAM.
// PARAMETERS
//  DEPTH        64  number of 32-bit words; power of two, 4..4096
//  WAIT_CYCLES  2   access latency in cycles, 0..15
// PORTS
//  clk        in   1   single clock; all state updates on rising edge
//  reset      in   1   synchronous, active-high
//  req_valid  in   1   request present
//  req_ready  out  1   responder can accept a request
//  req_we     in   1   1 = store, 0 = load
//  req_addr   in   32  byte address
//  req_wdata  in   32  store data
//  req_be     in   4   byte-lane enables, bit i = bits [8i+7:8i]
//  rsp_valid  out  1   response present
//  rsp_ready  in   1   requester accepts the response
//  rsp_rdata  out  32  load data; 0 for stores and for errors
//  rsp_err    out  1   misaligned or out-of-range access
//  busy       out  1   state != IDLE
// BEHAVIOUR
//  - Reset: state=IDLE, wait counter=0, rsp_valid=0, rsp_rdata=0, rsp_err=0.
//    req_ready=0 while reset is high. RAM contents are not cleared.
//  - FSM states: IDLE, WAIT, RESP.
//    - IDLE: req_ready=1. At an edge with req_valid=1, capture we/addr/wdata/be.
//      Go to RESP if WAIT_CYCLES==0; otherwise go to WAIT with counter=WAIT_CYCLES-1.
//    - WAIT: req_ready=0. Decrement the counter each edge. At an edge with
//      counter==0, go to RESP.
//    - On entry to RESP (the same edge): commit the store, or register the load
//      data from RAM[idx], and register rsp_err.
//    - RESP: rsp_valid=1. rsp_rdata and rsp_err hold stable while rsp_ready=0.
//      At an edge with rsp_ready=1, go to IDLE and clear rsp_valid, rsp_rdata
//      and rsp_err to 0.
//  - Latency: accept at edge E. rsp_valid=1 in the cycle after edge E+WAIT_CYCLES.
//    Minimum time from one accept to the next accept is WAIT_CYCLES+2 edges.
//    No overlap and no pipelining: req_ready=0 in WAIT and in RESP.
//  - Addressing: idx = addr[$clog2(DEPTH)+1:2].
//    Error when addr[1:0]!=0 OR addr[31:2]>=DEPTH.
//    On error: no RAM write, rsp_rdata=0, rsp_err=1.
//  - Stores return rsp_rdata=0, rsp_err=0 (unless in error).
//  - A load issued right after a store to the same address returns the new data.
//  - Reset mid-operation (WAIT or RESP): abort, return to IDLE, no store commit.
//    A store already committed on RESP entry stays in RAM.
//  - req_valid=1 while not in IDLE is ignored; the requester must hold it.
//  - Counter never wraps; WAIT_CYCLES>15 is illegal (elaboration $error).
// CONFIGURATION
//  DMEM_BYTE_EN defined:
//    - Stores write only the lanes whose req_be bit is 1.
//    - req_be=4'b0000 performs no write and returns rsp_err=0.
//    - Loads ignore req_be and return the full word.
//  DMEM_BYTE_EN undefined:
//    - req_be is ignored; every store writes the full 32-bit word.
// TESTING
//  1. Reset, then store addr=100 wdata=7, then load addr=100 (WAIT_CYCLES=2)
//     -> rsp_valid 3 cycles after each accept; load returns rsp_rdata=7, rsp_err=0.
//  2. Load addr=0x102 -> rsp_err=1, rsp_rdata=0.
//     Store addr=256 (DEPTH=64) -> rsp_err=1; a later load of addr=0 is unchanged.
//  3. Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid/rsp_rdata stable and
//     req_ready=0; accept occurs only after the rsp_ready handshake.
//  4. WAIT_CYCLES=0: back-to-back loads with rsp_ready=1 -> accepts every 2nd edge,
//     each response exactly 1 cycle after its accept.
//  5. Assert reset in WAIT of a store addr=8 wdata=0xDEAD -> IDLE next cycle,
//     rsp_valid=0; a later load of addr=8 returns the old value.
//  6. DMEM_BYTE_EN: store 0x11223344 be=1111, then store 0xAABBCCDD be=0101 to
//     addr=4 -> load returns 0x11BB33DD.

Source files
------------

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: one load/store at a time, WAIT_CYCLES of latency, response handshake.
// Optional DMEM_BYTE_EN: stores honour the req_be_i lane enables; otherwise every store writes the full word.
module dmem_responder #(
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [3:0]  req_be_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic        busy_o
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
        $error("dmem_responder: WAIT_CYCLES must be in 0..15");
    end
    if (DEPTH < 4 || DEPTH > 4096 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("dmem_responder: DEPTH must be a power of two in 4..4096");
    end

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [31:0] mem [DEPTH];

    logic          in_idle;
    logic          go_resp;
    logic          acc_we;
    logic [31:0]   acc_addr;
    logic [31:0]   acc_wdata;
    logic          acc_err;
    logic [AW-1:0] acc_idx;
    logic          commit_we;

    // The access is taken straight from the request when RESP is entered from IDLE.
    assign in_idle   = (state_q == S_IDLE);
    assign acc_we    = in_idle ? req_we_i    : we_q;
    assign acc_addr  = in_idle ? req_addr_i  : addr_q;
    assign acc_wdata = in_idle ? req_wdata_i : wdata_q;
    assign acc_err   = (acc_addr[1:0] != 2'b00) || (acc_addr[31:AW+2] != '0);
    assign acc_idx   = acc_addr[AW+1:2];
    assign commit_we = go_resp && acc_we && !acc_err && !reset_i;

`ifdef DMEM_BYTE_EN
    logic [3:0] be_q, be_d;
    logic [3:0] acc_be;
    assign acc_be = in_idle ? req_be_i : be_q;
`else
    logic unused_be;
    assign unused_be = ^req_be_i;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        go_resp = 1'b0;
`ifdef DMEM_BYTE_EN
        be_d    = be_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    we_d    = req_we_i;
                    addr_d  = req_addr_i;
                    wdata_d = req_wdata_i;
`ifdef DMEM_BYTE_EN
                    be_d    = req_be_i;
`endif
                    if (WAIT_CYCLES == 0) begin
                        state_d = S_RESP;
                        go_resp = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = WAIT_INIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_RESP;
                    go_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                if (rsp_ready_i) begin
                    state_d = S_IDLE;
                    rdata_d = '0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (go_resp) begin
            err_d   = acc_err;
            rdata_d = (acc_we || acc_err) ? 32'd0 : mem[acc_idx];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
`ifdef DMEM_BYTE_EN
            be_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
`ifdef DMEM_BYTE_EN
            be_q    <= be_d;
`endif
        end
    end

    // NOTE: the RAM array is deliberately not reset; contents survive reset and map onto plain RAM.
    always_ff @(posedge clk_i) begin
        if (commit_we) begin
`ifdef DMEM_BYTE_EN
            for (int i = 0; i < 4; i++) begin
                if (acc_be[i]) begin
                    mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
                end
            end
`else
            mem[acc_idx] <= acc_wdata;
`endif
        end
    end

    assign req_ready_o = in_idle && !reset_i;
    assign rsp_valid_o = (state_q == S_RESP);
    assign rsp_rdata_o = rdata_q;
    assign rsp_err_o   = err_q;
    assign busy_o      = !in_idle;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder against a word-array reference model.
// A second instance with WAIT_CYCLES=0 covers back-to-back accepts.
module tb_dmem_responder;

    localparam int DEPTH   = 64;
    localparam int WC      = 2;
    localparam int Z_DEPTH = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err, busy;
    logic [31:0] req_addr, req_wdata, rsp_rdata;
    logic [3:0]  req_be;

    logic        z_reset, z_req_valid, z_req_ready, z_req_we, z_rsp_valid, z_rsp_ready, z_rsp_err, z_busy;
    logic [31:0] z_req_addr, z_req_wdata, z_rsp_rdata;
    logic [3:0]  z_req_be;

    dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(WC)) u_dut (
        .clk_i(clk), .reset_i(reset),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_be_i(req_be),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err), .busy_o(busy)
    );

    dmem_responder #(.DEPTH(Z_DEPTH), .WAIT_CYCLES(0)) u_dut_z (
        .clk_i(clk), .reset_i(z_reset),
        .req_valid_i(z_req_valid), .req_ready_o(z_req_ready), .req_we_i(z_req_we),
        .req_addr_i(z_req_addr), .req_wdata_i(z_req_wdata), .req_be_i(z_req_be),
        .rsp_valid_o(z_rsp_valid), .rsp_ready_i(z_rsp_ready),
        .rsp_rdata_o(z_rsp_rdata), .rsp_err_o(z_rsp_err), .busy_o(z_busy)
    );

    int checks = 0;
    int errors = 0;
    logic [31:0] model_mem [DEPTH];
    logic [31:0] z_mem [Z_DEPTH];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic addr_err(input logic [31:0] a, input int depth);
        return (a[1:0] != 2'b00) || ((a >> 2) >= 32'(depth));
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wdata,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
`ifdef DMEM_BYTE_EN
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = wdata[8*i +: 8];
`else
        r = wdata;
`endif
        return r;
    endfunction

    // Start and finish just after a falling edge.
    task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, input int hold);
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          n;
        exp_err   = addr_err(addr, DEPTH);
        exp_rdata = 32'd0;
        if (!we && !exp_err) exp_rdata = model_mem[addr >> 2];

        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
        n = 0;
        while (!req_ready && n < 10) begin @(negedge clk); n++; end
        check("accept_ready", req_ready, 1'b1);
        @(posedge clk);
        if (we && !exp_err) model_mem[addr >> 2] = merge(model_mem[addr >> 2], wdata, be);
        @(negedge clk);
        // Junk on the request side must be ignored while busy.
        req_we = 1'($urandom); req_addr = $urandom; req_wdata = $urandom; req_be = 4'($urandom);

        n = 0;
        while (!rsp_valid && n < 20) begin
            check("wait_busy", busy, 1'b1);
            @(negedge clk); n++;
        end
        check("latency", n, WC);
        check("resp_ready_low", req_ready, 1'b0);
        repeat (hold) begin
            check("hold_valid", rsp_valid, 1'b1);
            check("hold_rdata", rsp_rdata, exp_rdata);
            check("hold_err", rsp_err, exp_err);
            check("hold_req_ready", req_ready, 1'b0);
            @(negedge clk);
        end
        check("rdata", rsp_rdata, exp_rdata);
        check("err", rsp_err, exp_err);
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0; req_valid = 1'b0;
        check("clr_valid", rsp_valid, 1'b0);
        check("clr_rdata", rsp_rdata, 32'd0);
        check("clr_err", rsp_err, 1'b0);
        check("idle_busy", busy, 1'b0);
        check("idle_ready", req_ready, 1'b1);
    endtask

    task automatic reset_abort(input logic [31:0] addr, input logic [31:0] wdata, input bit in_resp);
        int n;
        req_valid = 1'b1; req_we = 1'b1; req_addr = addr; req_wdata = wdata; req_be = 4'hF;
        n = 0;
        while (!req_ready && n < 10) begin @(negedge clk); n++; end
        check("abort_accept", req_ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        if (in_resp) begin
            model_mem[addr >> 2] = wdata;
            n = 0;
            while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
            check("abort_in_resp", rsp_valid, 1'b1);
        end else begin
            check("abort_in_wait", rsp_valid, 1'b0);
        end
        check("abort_busy", busy, 1'b1);
        reset = 1'b1;
        #1;
        check("rst_ready_low", req_ready, 1'b0);
        @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_valid", rsp_valid, 1'b0);
        check("rst_rdata", rsp_rdata, 32'd0);
        check("rst_err", rsp_err, 1'b0);
        reset = 1'b0;
        #1;
        check("rst_release_ready", req_ready, 1'b1);
    endtask

    initial begin
        logic [31:0] z_addr [6];
        logic        z_we   [6];
        logic [31:0] z_wd   [6];
        logic [31:0] a;
        logic [31:0] exp_d;
        logic        exp_e;

        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
        rsp_ready = 1'b0;
        z_reset = 1'b1; z_req_valid = 1'b0; z_req_we = 1'b0; z_req_addr = '0; z_req_wdata = '0;
        z_req_be = 4'hF; z_rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_ready", req_ready, 1'b0);
        check("reset_valid", rsp_valid, 1'b0);
        check("reset_rdata", rsp_rdata, 32'd0);
        check("reset_err", rsp_err, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("z_reset_valid", z_rsp_valid, 1'b0);
        reset = 1'b0; z_reset = 1'b0;
        #1;
        check("post_reset_ready", req_ready, 1'b1);

        for (int i = 0; i < DEPTH; i++) txn(1'b1, 32'(i * 4), $urandom, 4'hF, 0);

        txn(1'b1, 32'd100, 32'd7, 4'hF, 0);
        txn(1'b0, 32'd100, 32'd0, 4'hF, 0);
        txn(1'b0, 32'h102, 32'd0, 4'hF, 0);
        txn(1'b1, 32'd256, 32'hFFFF_FFFF, 4'hF, 0);
        txn(1'b0, 32'd0, 32'd0, 4'hF, 0);
        txn(1'b0, 32'd100, 32'd0, 4'hF, 5);

        reset_abort(32'd8, 32'h0000_DEAD, 1'b0);
        txn(1'b0, 32'd8, 32'd0, 4'hF, 0);
        reset_abort(32'd12, 32'h1234_5678, 1'b1);
        txn(1'b0, 32'd12, 32'd0, 4'hF, 0);

        txn(1'b1, 32'd4, 32'h1122_3344, 4'hF, 0);
        txn(1'b1, 32'd4, 32'hAABB_CCDD, 4'b0101, 0);
        txn(1'b0, 32'd4, 32'd0, 4'hF, 0);
        txn(1'b1, 32'd16, 32'hFFFF_FFFF, 4'b0000, 0);
        txn(1'b0, 32'd16, 32'd0, 4'hF, 0);
        txn(1'b0, 32'd252, 32'd0, 4'hF, 0);

        for (int i = 0; i < 80; i++) begin
            case ($urandom_range(0, 9))
                0:       a = 32'($urandom_range(0, DEPTH - 1) * 4) | 32'($urandom_range(1, 3));
                1:       a = 32'($urandom_range(DEPTH, 4095) * 4);
                default: a = 32'($urandom_range(0, DEPTH - 1) * 4);
            endcase
            txn(1'($urandom), a, $urandom, 4'($urandom), int'($urandom_range(0, 3)));
        end

        // WAIT_CYCLES=0 instance: back-to-back requests with rsp_ready held high.
        z_we[0] = 1'b1; z_addr[0] = 32'd12; z_wd[0] = 32'hCAFE_0001;
        z_we[1] = 1'b0; z_addr[1] = 32'd12; z_wd[1] = 32'd0;
        z_we[2] = 1'b1; z_addr[2] = 32'd0;  z_wd[2] = 32'h0000_0005;
        z_we[3] = 1'b0; z_addr[3] = 32'd0;  z_wd[3] = 32'd0;
        z_we[4] = 1'b0; z_addr[4] = 32'd64; z_wd[4] = 32'd0;
        z_we[5] = 1'b0; z_addr[5] = 32'd12; z_wd[5] = 32'd0;
        z_req_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            z_req_we = z_we[i]; z_req_addr = z_addr[i]; z_req_wdata = z_wd[i];
            exp_e = addr_err(z_addr[i], Z_DEPTH);
            exp_d = 32'd0;
            if (!z_we[i] && !exp_e) exp_d = z_mem[z_addr[i] >> 2];
            if (z_we[i] && !exp_e) z_mem[z_addr[i] >> 2] = z_wd[i];
            check("z_idle_ready", z_req_ready, 1'b1);
            check("z_idle_valid", z_rsp_valid, 1'b0);
            @(posedge clk);
            @(negedge clk);
            check("z_rsp_valid", z_rsp_valid, 1'b1);
            check("z_rsp_rdata", z_rsp_rdata, exp_d);
            check("z_rsp_err", z_rsp_err, exp_e);
            check("z_resp_ready_low", z_req_ready, 1'b0);
            @(posedge clk);
            @(negedge clk);
        end
        z_req_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout");
        $fatal(1, "simulation time limit reached");
    end

endmodule
